fifo_drain_ctrl: RTL and testbench
==================================

// Module: fifo_drain_ctrl
// PURPOSE
//  Downstream consumer of the fifo block. Pops words from the FIFO and forwards them to a sink over valid/ready.
//  Waits until a programmable burst threshold is reached, or a timeout expires, then drains one burst.
//  Absorbs the FIFO's 1-cycle read latency in a 2-entry skid buffer, so no word is lost under back-pressure.
// PARAMETERS
//  DATA_W   4  width of fifo_buffer_out / sink_data
//  CNT_W    4  width of fifo_data_count / burst_thr
//  TIMEOUT  8  max cycles in FILL before draining a partial burst (>=1)
// PORTS
//  clk               in   1       single clock, all logic on posedge
//  reset             in   1       synchronous, active-high
//  fifo_empty        in   1       FIFO empty flag
//  fifo_data_count   in   CNT_W   FIFO occupancy; updates on the edge that retires a read
//  fifo_buffer_out   in   DATA_W  FIFO read data; valid the cycle after fifo_read
//  fifo_error        in   1       FIFO error flag
//  burst_thr         in   CNT_W   burst length/threshold; 0 treated as 1
//  sink_ready        in   1       sink accepts sink_data this cycle
//  fifo_read         out  1       FIFO pop strobe (combinational from regs + sink_ready)
//  sink_valid        out  1       skid head valid
//  sink_data         out  DATA_W  skid head data
//  sink_last         out  1       head word is the last word of its burst
//  err_sticky        out  1       set by fifo_error, cleared only by reset
//  state_o           out  2       current FSM state (debug)
// BEHAVIOUR
//  Reset (sync, high): state=IDLE; timer, burst_cnt, rd_pend, skid cleared.
//   fifo_read=0, sink_valid=0, sink_data=0, sink_last=0, err_sticky=0, state_o=IDLE.
//   Reset mid-burst flushes the skid; any word already popped is discarded.
//  FSM: IDLE=0, FILL=1, DRAIN=2 (3 unused -> IDLE).
//   IDLE : fifo_data_count!=0 -> FILL; timer<=0.
//   FILL : timer++ each cycle. Go to DRAIN with burst_cnt<=0 when either
//          fifo_data_count>=eff_thr, or timer==TIMEOUT-1.
//   DRAIN: issue reads. Leave -> IDLE on the cycle the last read is issued.
//  Read issue: fifo_read = (state==DRAIN) && !fifo_empty && (fifo_data_count!=0)
//   && (skid_cnt - pop + rd_pend) < 2, where pop = sink_valid && sink_ready.
//   Sustains 1 word/cycle while sink_ready=1. Never reads an empty FIFO.
//  Last tag, computed at issue: last = (burst_cnt+1==eff_thr) || (fifo_data_count==1).
//   The tag travels with the read and ends DRAIN. burst_cnt is CNT_W+1 bits, no wrap.
//  Latency: read at cycle t -> rd_pend=1 in t+1 -> fifo_buffer_out captured into skid at end of t+1.
//   If skid was empty, the word appears on sink_data in t+2.
//  Skid: 2-entry in-order queue. Simultaneous push+pop allowed; count unchanged.
//   Push into a full skid is impossible by construction; the bench asserts this.
//  sink_valid/sink_data/sink_last hold stable while sink_valid && !sink_ready.
//  err_sticky <= err_sticky | fifo_error. fifo_error does not stop draining.
// STRUCTURE
//  Shared include fifo_defs.vh: state encodings ST_IDLE/ST_FILL/ST_DRAIN; default DATA_W/CNT_W
//   (shared with fifo, which uses 4).
//  Sub-module pop_skid_buf (2-entry, DATA_W+1 wide incl. last): push, data, pop -> valid, data, count.
//  Top level holds the FSM, timer, burst_cnt, rd_pend, issue logic and err_sticky.
// TESTING (behavioural vs synthesized netlist, outputs compared every cycle)
//  1 reset=1 for 2 cycles with FIFO holding data -> fifo_read=0, sink_valid=0, state_o=0, err_sticky=0.
//  2 burst_thr=4; write 1,2,3,4; sink_ready=1 -> fifo_read high 4 consecutive cycles.
//    sink_data=1,2,3,4 on consecutive cycles starting 2 after the first read; sink_last only on 4; IDLE after.
//  3 burst_thr=8, TIMEOUT=8; write 0xA,0xB -> 8 cycles in FILL, then 2 reads; 0xA then 0xB, last on 0xB.
//  4 burst_thr=4, 4 words, sink_ready=0 -> at most 2 reads, then fifo_read=0, sink_data frozen.
//    sink_ready=1 -> remaining words in order, none lost or duplicated.
//  5 one-cycle fifo_error pulse mid-DRAIN -> err_sticky=1 next cycle and held; draining completes.
//    Cleared only by reset.
//  6 reset during DRAIN with skid_cnt=2 -> next cycle sink_valid=0, state_o=IDLE.
//    FIFO remainder is drained normally after reset drops.

Source files
------------

// File: rtl/fifo_drain_ctrl_pkg.sv
// Shared definitions for the FIFO drain controller: FSM encoding and default widths.
// The FIFO block uses the same default widths.
package fifo_drain_ctrl_pkg;

  localparam int unsigned DEF_DATA_W = 4;
  localparam int unsigned DEF_CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/fifo_drain_ctrl_pop_skid_buf.sv
// Two-entry in-order skid queue absorbing the FIFO read latency.
// Entry e0 is always the head; push and pop may occur in the same cycle.
module pop_skid_buf #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] e0, e1;
  logic [1:0]   cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      e0  <= '0;
      e1  <= '0;
      cnt <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) e0 <= push_data;
          else             e1 <= push_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          // pop requires a valid head, so cnt is 1 or 2 here
          if (cnt == 2'd1) begin
            e0 <= push_data;
          end else begin
            e0 <= e1;
            e1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid = (cnt != 2'd0);
  assign head  = e0;
  assign count = cnt;

endmodule

// File: rtl/fifo_drain_ctrl.sv
// FIFO drain controller: waits for a burst threshold or timeout, then pops one burst
// from the FIFO and forwards it to a valid/ready sink through a 2-entry skid buffer.
module fifo_drain_ctrl
  import fifo_drain_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [CNT_W-1:0]  fifo_data_count,
  input  logic [DATA_W-1:0] fifo_buffer_out,
  input  logic              fifo_error,
  input  logic [CNT_W-1:0]  burst_thr,
  input  logic              sink_ready,
  output logic              fifo_read,
  output logic              sink_valid,
  output logic [DATA_W-1:0] sink_data,
  output logic              sink_last,
  output logic              err_sticky,
  output logic [1:0]        state_o
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  state_t            state, state_nxt;
  logic [TMR_W-1:0]  timer;
  logic [CNT_W:0]    burst_cnt;
  logic              rd_pend;
  logic              rd_last;
  logic [CNT_W-1:0]  eff_thr;
  logic              pop;
  logic              issue_last;
  logic [2:0]        occ;
  logic [1:0]        skid_cnt;
  logic              skid_valid;
  logic [DATA_W:0]   skid_head;

  assign eff_thr = (burst_thr == '0) ? CNT_W'(1) : burst_thr;
  assign pop     = skid_valid & sink_ready;
  // skid occupancy after this cycle's pop plus the word still in flight from the FIFO
  assign occ     = {1'b0, skid_cnt} + {2'b00, rd_pend} - {2'b00, pop};

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (fifo_data_count != '0) state_nxt = ST_FILL;
      ST_FILL:  if ((fifo_data_count >= eff_thr) || (timer == TMR_W'(TIMEOUT - 1)))
                  state_nxt = ST_DRAIN;
      ST_DRAIN: if (fifo_read && issue_last) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    fifo_read  = 1'b0;
    issue_last = ({1'b0, eff_thr} == (burst_cnt + (CNT_W + 1)'(1)))
               || (fifo_data_count == CNT_W'(1));
    if ((state == ST_DRAIN) && !fifo_empty && (fifo_data_count != '0) && (occ < 3'd2))
      fifo_read = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer      <= '0;
      burst_cnt  <= '0;
      rd_pend    <= 1'b0;
      rd_last    <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      rd_pend    <= fifo_read;
      rd_last    <= fifo_read & issue_last;
      err_sticky <= err_sticky | fifo_error;
      if (state == ST_IDLE)      timer <= '0;
      else if (state == ST_FILL) timer <= timer + TMR_W'(1);
      if ((state == ST_FILL) && (state_nxt == ST_DRAIN)) burst_cnt <= '0;
      else if (fifo_read)                                burst_cnt <= burst_cnt + (CNT_W + 1)'(1);
    end
  end

  pop_skid_buf #(.W(DATA_W + 1)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (rd_pend),
    .push_data ({rd_last, fifo_buffer_out}),
    .pop       (pop),
    .valid     (skid_valid),
    .head      (skid_head),
    .count     (skid_cnt)
  );

  assign sink_valid = skid_valid;
  assign sink_data  = skid_head[DATA_W-1:0];
  assign sink_last  = skid_valid & skid_head[DATA_W];
  assign state_o    = state;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed bench for fifo_drain_ctrl with a behavioural FIFO model (1-cycle read latency)
// and a sink-side log of accepted words.
module tb_fifo_drain_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fifo_empty = 1'b1;
  logic [3:0] fifo_data_count = '0;
  logic [3:0] fifo_buffer_out = '0;
  logic       fifo_error = 1'b0;
  logic [3:0] burst_thr = 4'd4;
  logic       sink_ready = 1'b0;
  logic       fifo_read;
  logic       sink_valid;
  logic [3:0] sink_data;
  logic       sink_last;
  logic       err_sticky;
  logic [1:0] state_o;

  logic       wr_req = 1'b0;
  logic [3:0] wr_data = '0;
  logic [3:0] fq[$];
  logic [3:0] rx_data[$];
  logic       rx_last[$];
  int         rx_cyc[$];
  int         rd_cyc[$];
  int         cyc = 0;
  int         n_run = 0;
  int         n_fail = 0;
  int         fill_cycles = 0;

  fifo_drain_ctrl #(.DATA_W(4), .CNT_W(4), .TIMEOUT(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .fifo_empty      (fifo_empty),
    .fifo_data_count (fifo_data_count),
    .fifo_buffer_out (fifo_buffer_out),
    .fifo_error      (fifo_error),
    .burst_thr       (burst_thr),
    .sink_ready      (sink_ready),
    .fifo_read       (fifo_read),
    .sink_valid      (sink_valid),
    .sink_data       (sink_data),
    .sink_last       (sink_last),
    .err_sticky      (err_sticky),
    .state_o         (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FIFO model, sink log and skid overflow guard
  always @(posedge clk) begin
    if (dut.rd_pend && (dut.skid_cnt == 2'd2) && !(sink_valid && sink_ready))
      check("skid_overflow", 1, 0);
    if (sink_valid && sink_ready) begin
      rx_data.push_back(sink_data);
      rx_last.push_back(sink_last);
      rx_cyc.push_back(cyc);
    end
    if (fifo_read) begin
      check("read_empty", fq.size() == 0, 0);
      if (fq.size() != 0) fifo_buffer_out <= fq.pop_front();
      rd_cyc.push_back(cyc);
    end
    if (wr_req) fq.push_back(wr_data);
    fifo_data_count <= 4'(fq.size());
    fifo_empty      <= (fq.size() == 0);
    if (state_o == 2'd1) fill_cycles++;
    cyc++;
  end

  task automatic write_words(input logic [3:0] w0, input logic [3:0] w1,
                             input logic [3:0] w2, input logic [3:0] w3, input int n);
    logic [3:0] w[4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int i = 0; i < n; i++) begin
      wr_req  = 1'b1;
      wr_data = w[i];
      @(negedge clk);
    end
    wr_req = 1'b0;
  endtask

  task automatic clear_logs();
    rx_data.delete();
    rx_last.delete();
    rx_cyc.delete();
    rd_cyc.delete();
    fill_cycles = 0;
  endtask

  task automatic wait_rx(input int n, input int budget, input string tag);
    int k = 0;
    while (rx_data.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_rx_timeout"}, rx_data.size() >= n, 1);
  endtask

  task automatic wait_rd(input int n, input int budget, input string tag);
    int k = 0;
    while (rd_cyc.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_rd_timeout"}, rd_cyc.size() >= n, 1);
  endtask

  initial begin
    // 1: reset held while the FIFO holds data
    @(negedge clk);
    write_words(4'h5, 4'h6, 4'h0, 4'h0, 2);
    check("rst_fifo_read", fifo_read, 0);
    check("rst_sink_valid", sink_valid, 0);
    check("rst_state", state_o, 0);
    check("rst_err", err_sticky, 0);
    check("rst_sink_data", sink_data, 0);
    check("rst_sink_last", sink_last, 0);
    clear_logs();
    burst_thr  = 4'd2;
    sink_ready = 1'b1;
    reset      = 1'b0;
    wait_rx(2, 40, "t1");
    check("t1_n", rx_data.size(), 2);
    check("t1_d0", rx_data[0], 4'h5);
    check("t1_d1", rx_data[1], 4'h6);
    check("t1_l0", rx_last[0], 0);
    check("t1_l1", rx_last[1], 1);
    repeat (3) @(negedge clk);

    // 2: full burst of 4 at full rate
    clear_logs();
    burst_thr = 4'd4;
    write_words(4'h1, 4'h2, 4'h3, 4'h4, 4);
    wait_rx(4, 40, "t2");
    @(negedge clk);
    check("t2_nrd", rd_cyc.size(), 4);
    check("t2_nrx", rx_data.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("t2_rd_cyc", rd_cyc[i], rd_cyc[0] + i);
      check("t2_rx_cyc", rx_cyc[i], rd_cyc[0] + 2 + i);
      check("t2_data", rx_data[i], 4'(i + 1));
      check("t2_last", rx_last[i], (i == 3) ? 1 : 0);
    end
    check("t2_idle", state_o, 0);
    repeat (2) @(negedge clk);

    // 3: partial burst drained by timeout
    clear_logs();
    burst_thr = 4'd8;
    write_words(4'hA, 4'hB, 4'h0, 4'h0, 2);
    wait_rx(2, 60, "t3");
    @(negedge clk);
    check("t3_fill_cycles", fill_cycles, 8);
    check("t3_nrd", rd_cyc.size(), 2);
    check("t3_d0", rx_data[0], 4'hA);
    check("t3_d1", rx_data[1], 4'hB);
    check("t3_l0", rx_last[0], 0);
    check("t3_l1", rx_last[1], 1);
    repeat (2) @(negedge clk);

    // 4: back-pressure stalls reads at two outstanding words
    clear_logs();
    burst_thr  = 4'd4;
    sink_ready = 1'b0;
    write_words(4'h1, 4'h2, 4'h3, 4'h4, 4);
    wait_rd(2, 40, "t4");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_stall_rd", fifo_read, 0);
      check("t4_frozen_v", sink_valid, 1);
      check("t4_frozen_d", sink_data, 4'h1);
    end
    check("t4_nrd_stall", rd_cyc.size(), 2);
    sink_ready = 1'b1;
    wait_rx(4, 40, "t4");
    repeat (3) @(negedge clk);
    check("t4_nrx", rx_data.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("t4_data", rx_data[i], 4'(i + 1));
      check("t4_last", rx_last[i], (i == 3) ? 1 : 0);
    end

    // 5: error pulse mid-drain
    clear_logs();
    write_words(4'hC, 4'hD, 4'hE, 4'hF, 4);
    wait_rd(1, 40, "t5");
    check("t5_err_pre", err_sticky, 0);
    fifo_error = 1'b1;
    @(negedge clk);
    fifo_error = 1'b0;
    check("t5_err_set", err_sticky, 1);
    wait_rx(4, 40, "t5");
    repeat (3) @(negedge clk);
    check("t5_err_hold", err_sticky, 1);
    check("t5_nrx", rx_data.size(), 4);
    check("t5_d3", rx_data[3], 4'hF);
    check("t5_l3", rx_last[3], 1);

    // 6: reset while the skid is full
    clear_logs();
    sink_ready = 1'b0;
    write_words(4'h7, 4'h8, 4'h9, 4'hA, 4);
    wait_rd(2, 40, "t6");
    repeat (2) @(negedge clk);
    check("t6_pre_valid", sink_valid, 1);
    check("t6_pre_skid", dut.skid_cnt, 2);
    reset = 1'b1;
    @(negedge clk);
    check("t6_rst_valid", sink_valid, 0);
    check("t6_rst_state", state_o, 0);
    check("t6_rst_err", err_sticky, 0);
    reset      = 1'b0;
    sink_ready = 1'b1;
    wait_rx(2, 60, "t6");
    repeat (3) @(negedge clk);
    check("t6_nrx", rx_data.size(), 2);
    check("t6_d0", rx_data[0], 4'h9);
    check("t6_d1", rx_data[1], 4'hA);
    check("t6_l1", rx_last[1], 1);
    check("t6_state_end", state_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
